// File: rtl/staggered_pkg.sv
// Shared widths and reference arithmetic for the staggered add/sub datapath.
// Latency: n/a (package); backpressure: n/a.
package staggered_pkg;
  localparam int N_DEF     = 16;
  localparam int CHUNK_DEF = 4;

  typedef logic [CHUNK_DEF-1:0] slice_t;

  function automatic logic [N_DEF:0] ref_sub(input logic [N_DEF-1:0] a,
                                             input logic [N_DEF-1:0] b,
                                             input logic             bi);
    return {1'b0, a} - {1'b0, b} - {{N_DEF{1'b0}}, bi};
  endfunction
endpackage

// File: rtl/staggered_sub_chunk.sv
// One slice of the borrow-chain subtractor: {bout, d} = a - b - bin.
// Combinational, zero latency; no flow control.
module sub_chunk
  import staggered_pkg::*;
#(
  parameter int W = CHUNK_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] diff;

  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = diff[W-1:0];
    bout = diff[W];
  end
endmodule

// File: rtl/staggered_sub.sv
// Pipelined N-bit subtract-with-borrow, one CHUNK-bit slice resolved per stage.
// Latency N/CHUNK cycles, one op per cycle, no backpressure (valid-only).
module staggered_sub
  import staggered_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         InValid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         BI,
  output logic         OutValid,
  output logic [N-1:0] D,
  output logic         BO
);
  localparam int STAGES = N / CHUNK;

  if ((N % CHUNK) != 0) begin : g_bad_cfg
    $error("staggered_sub: N must be a multiple of CHUNK");
  end

  // Per-stage registers; res holds finished low slices, opa/opb skew the unresolved high slices.
  logic         vld_q [STAGES];
  logic         vld_d [STAGES];
  logic         brw_q [STAGES];
  logic         brw_d [STAGES];
  logic [N-1:0] res_q [STAGES];
  logic [N-1:0] res_d [STAGES];
  logic [N-1:0] opa_q [STAGES];
  logic [N-1:0] opa_d [STAGES];
  logic [N-1:0] opb_q [STAGES];
  logic [N-1:0] opb_d [STAGES];

  logic             src_vld [STAGES];
  logic             src_brw [STAGES];
  logic [N-1:0]     src_res [STAGES];
  logic [N-1:0]     src_a   [STAGES];
  logic [N-1:0]     src_b   [STAGES];
  logic [CHUNK-1:0] ch_d    [STAGES];
  logic             ch_bout [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_vld[k] = InValid;
      assign src_brw[k] = BI;
      assign src_res[k] = '0;
      assign src_a[k]   = A;
      assign src_b[k]   = B;
    end else begin : g_next
      assign src_vld[k] = vld_q[k-1];
      assign src_brw[k] = brw_q[k-1];
      assign src_res[k] = res_q[k-1];
      assign src_a[k]   = opa_q[k-1];
      assign src_b[k]   = opb_q[k-1];
    end

    sub_chunk #(.W(CHUNK)) u_sub_chunk (
      .a    (src_a[k][k*CHUNK +: CHUNK]),
      .b    (src_b[k][k*CHUNK +: CHUNK]),
      .bin  (src_brw[k]),
      .d    (ch_d[k]),
      .bout (ch_bout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = src_vld[k];
      brw_d[k] = brw_q[k];
      res_d[k] = res_q[k];
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      // Data only moves with a valid op, so outputs hold the last result through gaps.
      if (src_vld[k]) begin
        brw_d[k] = ch_bout[k];
        res_d[k] = src_res[k];
        res_d[k][k*CHUNK +: CHUNK] = ch_d[k];
        opa_d[k] = src_a[k];
        opb_d[k] = src_b[k];
      end
      if (Reset) begin
        vld_d[k] = 1'b0;
        brw_d[k] = 1'b0;
        res_d[k] = '0;
        opa_d[k] = '0;
        opb_d[k] = '0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    vld_q <= vld_d;
    brw_q <= brw_d;
    res_q <= res_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign OutValid = vld_q[STAGES-1];
  assign D        = res_q[STAGES-1];
  assign BO       = brw_q[STAGES-1];
endmodule

// File: tb/tb_staggered_sub.sv
// Directed self-checking bench for staggered_sub at N=16, CHUNK=4 (4-cycle latency).
module tb_staggered_sub;
  import staggered_pkg::*;

  localparam int LAT = 4;
  localparam int NV  = 12;
  localparam int NX  = 512;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [15:0] a;
  logic [15:0] b;
  logic        bi;
  logic        out_vld;
  logic [15:0] d;
  logic        bo;

  int checks = 0;
  int errors = 0;
  int mism   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  vec_t        vt [NV];
  logic [16:0] exh_exp [NX];

  staggered_sub dut (
    .Clock    (clk),
    .Reset    (rst),
    .InValid  (in_vld),
    .A        (a),
    .B        (b),
    .BI       (bi),
    .OutValid (out_vld),
    .D        (d),
    .BO       (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic [15:0] ed, input logic ebo);
    check({name, "_vld"}, 32'(out_vld), 32'(ev));
    check({name, "_d"},   32'(d),       32'(ed));
    check({name, "_bo"},  32'(bo),      32'(ebo));
  endtask

  task automatic drive(input logic v, input logic [15:0] va, input logic [15:0] vb, input logic vbi);
    in_vld = v;
    a      = va;
    b      = vb;
    bi     = vbi;
  endtask

  initial begin
    vt[0]  = '{16'h0007, 16'h0003, 1'b0, 16'h0004, 1'b0};
    vt[1]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vt[2]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vt[3]  = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
    vt[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0};
    vt[5]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vt[6]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
    vt[9]  = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1};
    vt[10] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0};
    vt[11] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'hE1E0, 1'b0};

    // Reset with garbage on the inputs, then idle: outputs must sit at zero.
    rst = 1'b1;
    drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_out("reset_idle", 1'b0, 16'h0000, 1'b0);
    end

    // Directed table, issued back-to-back; result j appears after the 4th edge from its issue.
    for (int i = 0; i < NV + LAT - 1; i++) begin
      if (i < NV) drive(1'b1, vt[i].a, vt[i].b, vt[i].bi);
      else        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      step();
      if (i >= LAT - 1) check_out($sformatf("vec%0d", i - (LAT - 1)), 1'b1,
                                  vt[i-(LAT-1)].d, vt[i-(LAT-1)].bo);
      else              check("vec_fill_vld", 32'(out_vld), 32'd0);
    end
    step();
    check("vec_drain_vld", 32'(out_vld), 32'd0);

    // Exhaustive low-nibble sweep back-to-back.
    for (int i = 0; i < NX; i++)
      exh_exp[i] = ref_sub(16'(i / 32), 16'((i / 2) % 16), 1'(i % 2));
    for (int i = 0; i < NX + LAT - 1; i++) begin
      if (i < NX) drive(1'b1, 16'(i / 32), 16'((i / 2) % 16), 1'(i % 2));
      else        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      step();
      if (i >= LAT - 1) begin
        checks++;
        if (out_vld !== 1'b1 || {bo, d} !== exh_exp[i-(LAT-1)]) begin
          errors++;
          mism++;
          $display("FAIL exh%0d got vld=%b %h expected vld=1 %h",
                   i - (LAT - 1), out_vld, {bo, d}, exh_exp[i-(LAT-1)]);
        end
      end
    end
    if (mism == 0) $display("No ERROR FOUND");
    else           $display("exhaustive sweep: %0d bad results", mism);
    step();
    check("exh_drain_vld", 32'(out_vld), 32'd0);

    // Three ops, then Reset while they are in flight; only the post-reset op may emerge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0005 + 16'(i), 16'h0001, 1'b0);
      step();
      check("rst_pre_vld", 32'(out_vld), 32'd0);
    end
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    step();
    rst = 1'b0;
    check_out("rst_flush", 1'b0, 16'h0000, 1'b0);
    drive(1'b1, 16'h0010, 16'h0001, 1'b0);
    step();
    check("rst_post0_vld", 32'(out_vld), 32'd0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("rst_wait", 1'b0, 16'h0000, 1'b0);
    end
    step();
    check_out("rst_result", 1'b1, 16'h000F, 1'b0);
    step();
    check_out("rst_after", 1'b0, 16'h000F, 1'b0);

    // Valid pattern 1,0,0,1 must reappear intact; D/BO hold across the gap.
    for (int i = 0; i < LAT + 3; i++) begin
      if (i < 4) drive((i == 0 || i == 3), 16'h00FF, 16'h0100, 1'b0);
      else       drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      step();
      if (i >= 3) check_out($sformatf("gap%0d", i - 3), (i == 3 || i == 6), 16'hFFFF, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
